// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier controller.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SPM_WIDTH     = 32;
  localparam int SPM_CHAIN_LAT = 1;

  // Wide enough to hold 2*width + lat, the full RUN span plus one.
  function automatic int cnt_width(input int width, input int lat);
    return $clog2(2 * width + lat + 1);
  endfunction

endpackage

// File: rtl/spm_piso.sv
// Parallel-in serial-out shifter feeding the multiplier bits LSB-first into the CSA chain.
module spm_piso
  import spm_pkg::*;
#(
  parameter int WIDTH = SPM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic             fill,
  input  logic [WIDTH-1:0] din,
  output logic             y_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = din;
    end else if (shift_en) begin
      shreg_d = {fill, shreg_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Once WIDTH shifts have happened the register is all fill, so y_o
  // naturally carries the extension bit for the upper half of the run.
  assign y_o = shreg_q[0];

endmodule

// File: rtl/spm_ctrl.sv
// Operand sequencer and product collector for the spm carry-save chain.
// Define SPM_CTRL_SIGNED_EN for two's complement operation (multiplier sign-extended).
module spm_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH     = SPM_WIDTH,
  parameter int CHAIN_LAT = SPM_CHAIN_LAT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic [WIDTH-1:0]   x_o,
  output logic               y_o,
  output logic               chain_clr,
  input  logic               p_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int CNT_W   = cnt_width(WIDTH, CHAIN_LAT);
  localparam int RUN_LEN = 2 * WIDTH + CHAIN_LAT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CHAIN_LAT);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic                 fill_q, fill_d;
  logic                 piso_load;
  logic                 piso_shift;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    prod_d     = prod_q;
    fill_d     = fill_q;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d       = in_x;
          piso_load = 1'b1;
`ifdef SPM_CTRL_SIGNED_EN
          fill_d    = in_y[WIDTH-1];
`else
          fill_d    = 1'b0;
`endif
          state_d   = CLEAR;
        end
      end

      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end

      RUN: begin
        piso_shift = 1'b1;
        // The first CHAIN_LAT returned bits predate the first driven y bit.
        if (cnt_q >= CNT_CAP) begin
          prod_d = {p_i, prod_q[2*WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      prod_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      prod_q  <= prod_d;
      fill_q  <= fill_d;
    end
  end

  spm_piso #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .shift_en (piso_shift),
    .fill     (fill_q),
    .din      (in_y),
    .y_o      (y_o)
  );

  // The chain is held clear for as long as the controller is in reset.
  assign chain_clr = !rst || (state_q == CLEAR);
  assign in_ready  = rst && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign x_o       = x_q;
  assign out_p     = prod_q;

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl driving a behavioural serial-parallel CSA chain model.
module tb_spm_ctrl;

  localparam int W   = 8;
  localparam int LAT = 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_x;
  logic [W-1:0]   in_y;
  logic [W-1:0]   x_o;
  logic           y_o;
  logic           chain_clr;
  logic           p_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spm_ctrl #(
    .WIDTH     (W),
    .CHAIN_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .x_o       (x_o),
    .y_o       (y_o),
    .chain_clr (chain_clr),
    .p_i       (p_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  // Behavioural chain: accumulate y*x serially, emit LSB each cycle, one cycle of latency.
  logic signed [2*W+1:0] acc;
  logic                  p_q;
  assign p_i = p_q;

  always @(posedge clk) begin
    logic signed [2*W+1:0] xext;
    logic signed [2*W+1:0] sum;
`ifdef SPM_CTRL_SIGNED_EN
    xext = {{(W+2){x_o[W-1]}}, x_o};
`else
    xext = {{(W+2){1'b0}}, x_o};
`endif
    sum = acc + (y_o ? xext : '0);
    if (chain_clr) begin
      acc <= '0;
      p_q <= 1'b0;
    end else begin
      p_q <= sum[0];
      acc <= sum >>> 1;
    end
  end

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SPM_CTRL_SIGNED_EN
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
`else
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 200);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_p !== '0) begin errors++; $display("FAIL reset_out_p: got %h expected 0", out_p); end
    checks++; if (x_o !== '0) begin errors++; $display("FAIL reset_x_o: got %h expected 0", x_o); end
    checks++; if (y_o !== 1'b0) begin errors++; $display("FAIL reset_y_o: got %b expected 0", y_o); end
    checks++; if (chain_clr !== 1'b1) begin errors++; $display("FAIL reset_chain_clr: got %b expected 1", chain_clr); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (chain_clr !== 1'b0) begin errors++; $display("FAIL post_reset_chain_clr: got %b expected 0", chain_clr); end
  endtask

  task automatic test_basic;
    bit ok;
    int cyc;
    send(8'd3, 8'd5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_accept: in_ready never rose"); end
    wait_out(cyc);
    // Accept cycle is cycle 0; out_valid shows in cycle 2W+LAT+2, i.e. 2W+LAT+1 edges after accept.
    checks++; if (cyc !== 2*W+LAT+1) begin errors++; $display("FAIL basic_latency: got %0d edges expected %0d", cyc, 2*W+LAT+1); end
    checks++; if (out_p !== 16'd15) begin errors++; $display("FAIL basic_product: got %h expected 000f", out_p); end
    checks++; if (x_o !== 8'd3) begin errors++; $display("FAIL basic_x_hold: got %h expected 03", x_o); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_return_idle: in_ready %b out_valid %b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_extremes;
    bit ok;
    int cyc;
    logic [2*W-1:0] exp_max;
    logic [2*W-1:0] exp_neg;
`ifdef SPM_CTRL_SIGNED_EN
    exp_max = 16'h0001;
    exp_neg = 16'hFF80;
`else
    exp_max = 16'hFE01;
    exp_neg = 16'h0080;
`endif
    send(8'hFF, 8'hFF, ok);
    wait_out(cyc);
    checks++; if (!ok || cyc >= 200) begin errors++; $display("FAIL max_timeout: accept %b edges %0d", ok, cyc); end
    checks++; if (out_p !== exp_max) begin errors++; $display("FAIL max_product: got %h expected %h", out_p, exp_max); end
    @(posedge clk); #1;
    send(8'h80, 8'h01, ok);
    wait_out(cyc);
    checks++; if (!ok || cyc >= 200) begin errors++; $display("FAIL neg_timeout: accept %b edges %0d", ok, cyc); end
    checks++; if (out_p !== exp_neg) begin errors++; $display("FAIL neg_product: got %h expected %h", out_p, exp_neg); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit ok;
    int cyc;
    out_ready = 1'b0;
    send(8'd6, 8'd7, ok);
    wait_out(cyc);
    checks++; if (!ok || cyc >= 200) begin errors++; $display("FAIL bp_timeout: accept %b edges %0d", ok, cyc); end
    in_valid = 1'b1;
    in_x     = 8'hAA;
    in_y     = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: cycle %0d got %b expected 1", i, out_valid); end
      checks++; if (out_p !== 16'd42) begin errors++; $display("FAIL bp_out_p: cycle %0d got %h expected 002a", i, out_p); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", i, in_ready); end
      checks++; if (x_o !== 8'd6) begin errors++; $display("FAIL bp_x_o: cycle %0d got %h expected 06", i, x_o); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid %b in_ready %b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run;
    bit ok;
    bit seen;
    int cyc;
    send(8'd11, 8'd13, ok);
    // Accept edge was E0; after E6 the counter sits at 5.
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_p !== '0) begin errors++; $display("FAIL midrst_out_p: got %h expected 0", out_p); end
    checks++; if (x_o !== '0) begin errors++; $display("FAIL midrst_x_o: got %h expected 0", x_o); end
    checks++; if (y_o !== 1'b0) begin errors++; $display("FAIL midrst_y_o: got %b expected 0", y_o); end
    checks++; if (chain_clr !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: chain_clr %b in_ready %b expected 1 0", chain_clr, in_ready); end
    rst  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_pulse: got out_valid pulse expected none"); end
    send(8'd7, 8'd9, ok);
    wait_out(cyc);
    checks++; if (out_p !== 16'd63 || cyc >= 200) begin errors++; $display("FAIL midrst_fresh: got %h after %0d edges expected 003f", out_p, cyc); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int n;
    int cyc;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a    = W'($urandom);
      b    = W'($urandom);
      in_x = a;
      in_y = b;
      n    = 0;
      while (!in_ready && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      @(posedge clk); #1;
      wait_out(cyc);
      checks++; if (n >= 200 || cyc !== 2*W+LAT+1) begin errors++; $display("FAIL b2b_timing: pair %0d accept wait %0d latency %0d expected %0d", i, n, cyc, 2*W+LAT+1); end
      checks++; if (out_p !== ref_mul(a, b)) begin errors++; $display("FAIL b2b_product: pair %0d %h*%h got %h expected %h", i, a, b, out_p, ref_mul(a, b)); end
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready_rise: pair %0d in_ready %b out_valid %b expected 1 0", i, in_ready, out_valid); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
